// File: rtl/irq_source_arbiter.sv
// ---------------------------------------------------------------------------
// irq_source_arbiter
//   Source-side initiator of the core interrupt handshake. Latches up to 16
//   peripheral interrupt lines into pending bits (edge or level per source),
//   selects the lowest-index enabled pending source and presents it to the
//   interrupt controller as a single request plus mcause word. The chosen
//   source stays in service until the controller returns from the handler.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   src_irq_i    raw peripheral interrupt lines (synchronous to clk_i)
//   src_en_i     per-source enable mask (arbitration only)
//   irq_taken_i  controller accepted the request this cycle
//   irq_ret_i    controller return-from-interrupt pulse
//   irq_req_o    interrupt request to controller
//   irq_cause_o  mcause value for the active source
//   irq_id_o     index of the active source
//   pending_o    current pending vector
//   busy_o       a source is in service
// ---------------------------------------------------------------------------
module irq_source_arbiter #(
  parameter int unsigned NUM_SRC   = 16,
  parameter logic [15:0] EDGE_MASK = 16'h0000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_irq_i,
  input  logic [NUM_SRC-1:0] src_en_i,
  input  logic               irq_taken_i,
  input  logic               irq_ret_i,
  output logic               irq_req_o,
  output logic [31:0]        irq_cause_o,
  output logic [3:0]         irq_id_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_id;
  logic [3:0]         w_id_nxt;
  logic [NUM_SRC-1:0] r_prev;
  logic [NUM_SRC-1:0] r_pend;
  logic [NUM_SRC-1:0] w_pend_nxt;
  logic [NUM_SRC-1:0] w_edge_mask;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_elig;
  logic [NUM_SRC-1:0] w_act_onehot;
  logic               w_act_elig;
  logic [3:0]         w_win_id;
  logic               w_win_vld;
  logic               r_req;
  logic               r_busy;
  logic [31:0]        r_cause;

  // mcause for an external source: interrupt bit set, code 16 + id
  function automatic logic [31:0] cause_of(input logic [3:0] id);
    logic [4:0] code;
    code = 5'd16 + {1'b0, id};
    return {1'b1, 26'b0, code};
  endfunction

  assign w_edge_mask  = EDGE_MASK[NUM_SRC-1:0];
  assign w_rise       = src_irq_i & ~r_prev & w_edge_mask;
  assign w_elig       = r_pend & src_en_i;
  assign w_act_onehot = {{(NUM_SRC-1){1'b0}}, 1'b1} << r_id;
  assign w_act_elig   = |(w_elig & w_act_onehot);

  // Return-from-handler clears only the active edge bit; a new edge on the
  // same bit in that cycle wins because w_rise is ORed in after the clear.
  assign w_clr = ((r_state == ST_SERVICE) && irq_ret_i) ? (w_act_onehot & w_edge_mask)
                                                        : {NUM_SRC{1'b0}};
  assign w_pend_nxt = (w_edge_mask & ((r_pend & ~w_clr) | w_rise)) |
                      (~w_edge_mask & src_irq_i);

  // Fixed-priority encoder: scan downwards so the lowest index is kept last
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      w_win_vld = w_win_vld | w_elig[i];
      w_win_id  = w_elig[i] ? 4'(i) : w_win_id;
    end
  end

  // Handshake next-state logic; the id is only reloaded from IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    case (r_state)
      ST_IDLE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_REQ;
          w_id_nxt    = w_win_id;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_taken_i) begin
          w_state_nxt = ST_SERVICE;
        end else if (!w_act_elig) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (irq_ret_i) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_state_nxt = ST_SERVICE;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, pending and edge-history registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_id    <= 4'd0;
      r_prev  <= {NUM_SRC{1'b0}};
      r_pend  <= {NUM_SRC{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_id    <= w_id_nxt;
      r_prev  <= src_irq_i;
      r_pend  <= w_pend_nxt;
    end
  end

  // Output registers decoded from the next state so they align with r_state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_req   <= 1'b0;
      r_busy  <= 1'b0;
      r_cause <= 32'h8000_0010;
    end else begin
      r_req   <= (w_state_nxt == ST_REQ);
      r_busy  <= (w_state_nxt == ST_SERVICE);
      r_cause <= cause_of(w_id_nxt);
    end
  end

  assign irq_req_o   = r_req;
  assign busy_o      = r_busy;
  assign irq_cause_o = r_cause;
  assign irq_id_o    = r_id;
  assign pending_o   = r_pend;

endmodule
